// File: rtl/mips_rf_pkg.sv
// Shared constants and types for the MIPS register file and its scoreboard.
package mips_rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register busy flags: decode reserves a destination, writeback releases it.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic [ADDR_W-1:0] i_lk_addr_a,
  input  logic [ADDR_W-1:0] i_lk_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic              o_busy_any
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    w_busy_next = r_busy;
    if (i_wr_en) begin
      w_busy_next[i_wr_addr] = 1'b0;
    end
    if (i_rsv_en) begin
      w_busy_next[i_rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_next[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy_a   = r_busy[i_lk_addr_a];
  assign o_busy_b   = r_busy[i_lk_addr_b];
  assign o_busy_any = |r_busy;
endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS GPR file: two combinational read ports, one write port, write-to-read
// bypass, optional hardwired r0 and a reservation scoreboard for hazard logic.
module mips_regfile_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_any
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_raw_busy [2];
  logic              w_rd_busy [2];
  logic              w_wr_hit [2];
  logic              w_rsv_hit [2];
  logic              w_wr_drop;

  assign w_wr_drop = (ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && !w_wr_drop) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  mips_rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_rsv_en    (rsv_en),
    .i_rsv_addr  (rsv_addr),
    .i_lk_addr_a (rd_addr_a),
    .i_lk_addr_b (rd_addr_b),
    .o_busy_a    (w_raw_busy[0]),
    .o_busy_b    (w_raw_busy[1]),
    .o_busy_any  (busy_any)
  );

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      assign w_wr_hit[gi]  = wr_en && (wr_addr == w_rd_addr[gi]);
      assign w_rsv_hit[gi] = rsv_en && (rsv_addr == w_rd_addr[gi]);

      // rst masks the bypass too, so reads stay zero for the whole reset window.
      assign w_rd_data[gi] =
          (rst || ((ZERO_REG != 0) && (w_rd_addr[gi] == ADDR_W'(REG_ZERO)))) ? '0 :
          ((BYPASS != 0) && w_wr_hit[gi])                                   ? wr_data :
                                                                               r_mem[w_rd_addr[gi]];

      // A retiring write hides the busy flag unless a new producer reserves it.
      assign w_rd_busy[gi] = w_raw_busy[gi] &&
                             !((BYPASS != 0) && w_wr_hit[gi] && !w_rsv_hit[gi]);
    end
  endgenerate

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];
  assign rd_busy_a = w_rd_busy[0];
  assign rd_busy_b = w_rd_busy[1];
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural array model, on a default instance and a ZERO_REG=0/BYPASS=0 one.
module tb_mips_regfile_sb;
  import mips_rf_pkg::*;

  logic     clk;
  logic     rst;
  reg_idx_t rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  word_t    wr_data;
  logic     wr_en, rsv_en;

  word_t o_da [2];
  word_t o_db [2];
  logic  o_ba [2];
  logic  o_bb [2];
  logic  o_any [2];

  int total = 0;
  int bad   = 0;

  // cfg 0: ZERO_REG=1, BYPASS=1; cfg 1: ZERO_REG=0, BYPASS=0
  word_t m_mem [2][32];
  logic  m_busy [2][32];

  mips_regfile_sb u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(o_da[0]), .rd_data_b(o_db[0]),
    .rd_busy_a(o_ba[0]), .rd_busy_b(o_bb[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(o_any[0])
  );

  mips_regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_dut_nz (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(o_da[1]), .rd_data_b(o_db[1]),
    .rd_busy_a(o_ba[1]), .rd_busy_b(o_bb[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(o_any[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        m_mem[c][r]  = '0;
        m_busy[c][r] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    if (rst) return;
    for (int c = 0; c < 2; c++) begin
      if (wr_en && !(c == 0 && wr_addr == 0)) m_mem[c][wr_addr] = wr_data;
      if (wr_en) m_busy[c][wr_addr] = 1'b0;
      if (rsv_en && !(c == 0 && rsv_addr == 0)) m_busy[c][rsv_addr] = 1'b1;
    end
  endfunction

  function automatic word_t exp_rd(int c, reg_idx_t a);
    if (rst) return '0;
    if (c == 0 && a == 0) return '0;
    if (c == 0 && wr_en && wr_addr == a) return wr_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(int c, reg_idx_t a);
    if (c == 0 && wr_en && wr_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic exp_any(int c);
    logic any = 1'b0;
    for (int r = 0; r < 32; r++) any |= m_busy[c][r];
    return any;
  endfunction

  task automatic idle();
    wr_en = 0; rsv_en = 0; wr_addr = 0; rsv_addr = 0; wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    wr_en = 1; wr_addr = 3; wr_data = $urandom; rsv_en = 1; rsv_addr = 3;
    rd_addr_a = 3; rd_addr_b = 3;
    #2;
    for (int c = 0; c < 2; c++) begin
      total += 5;
      if (o_da[c] !== 0) begin bad++; $display("FAIL reset_da cfg%0d got=%h want=0", c, o_da[c]); end
      if (o_db[c] !== 0) begin bad++; $display("FAIL reset_db cfg%0d got=%h want=0", c, o_db[c]); end
      if (o_ba[c] !== 0) begin bad++; $display("FAIL reset_ba cfg%0d got=%b want=0", c, o_ba[c]); end
      if (o_bb[c] !== 0) begin bad++; $display("FAIL reset_bb cfg%0d got=%b want=0", c, o_bb[c]); end
      if (o_any[c] !== 0) begin bad++; $display("FAIL reset_any cfg%0d got=%b want=0", c, o_any[c]); end
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 0; idle();
    tick();
    for (int c = 0; c < 2; c++) begin
      total += 2;
      if (o_da[c] !== 0) begin bad++; $display("FAIL reset_prio_data cfg%0d got=%h want=0", c, o_da[c]); end
      if (o_any[c] !== 0) begin bad++; $display("FAIL reset_prio_busy cfg%0d got=%b want=0", c, o_any[c]); end
    end
    $display("txn reset done");
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
    tick();
    idle(); rd_addr_a = 5; rd_addr_b = 6;
    #1;
    total += 2;
    if (o_da[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_rst_r5 got=%h want=deadbeef", o_da[0]); end
    if (o_any[0] !== 1) begin bad++; $display("FAIL pre_rst_any got=%b want=1", o_any[0]); end
    #2 rst = 1; model_reset();
    #1;
    for (int c = 0; c < 2; c++) begin
      total += 2;
      if (o_da[c] !== 0) begin bad++; $display("FAIL async_rst_r5 cfg%0d got=%h want=0", c, o_da[c]); end
      if (o_any[c] !== 0) begin bad++; $display("FAIL async_rst_any cfg%0d got=%b want=0", c, o_any[c]); end
    end
    @(negedge clk); rst = 0;
    tick();
    $display("txn async_reset r5 cleared mid-cycle");
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rd_addr_a = 0; rd_addr_b = 0;
    #1;
    total += 2;
    if (o_da[0] !== 0) begin bad++; $display("FAIL r0_bypass_a got=%h want=0", o_da[0]); end
    if (o_db[0] !== 0) begin bad++; $display("FAIL r0_bypass_b got=%h want=0", o_db[0]); end
    tick();
    idle();
    #1;
    total += 4;
    if (o_da[0] !== 0) begin bad++; $display("FAIL r0_zr_a got=%h want=0", o_da[0]); end
    if (o_db[0] !== 0) begin bad++; $display("FAIL r0_zr_b got=%h want=0", o_db[0]); end
    if (o_da[1] !== 32'h12345678) begin bad++; $display("FAIL r0_plain_a got=%h want=12345678", o_da[1]); end
    if (o_db[1] !== 32'h12345678) begin bad++; $display("FAIL r0_plain_b got=%h want=12345678", o_db[1]); end
    wr_en = 1; wr_addr = 0; wr_data = 0;
    tick(); idle();
    $display("txn zero_reg write r0");
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 7; wr_data = 32'h11111111;
    tick();
    wr_data = 32'hA5A5A5A5; rd_addr_a = 7;
    #1;
    total += 2;
    if (o_da[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_on got=%h want=a5a5a5a5", o_da[0]); end
    if (o_da[1] !== 32'h11111111) begin bad++; $display("FAIL bypass_off_old got=%h want=11111111", o_da[1]); end
    tick();
    idle();
    #1;
    total += 2;
    if (o_da[1] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_off_new got=%h want=a5a5a5a5", o_da[1]); end
    if (o_da[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_on_new got=%h want=a5a5a5a5", o_da[0]); end
    $display("txn bypass r7");
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 9; rd_addr_b = 9; rd_addr_a = 9;
    #1;
    total++;
    if (o_bb[0] !== 0) begin bad++; $display("FAIL rsv_before_edge got=%b want=0", o_bb[0]); end
    tick(); idle();
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc == 3) begin wr_en = 1; wr_addr = 9; wr_data = 32'h0000_0909; end
      #1;
      total += 2;
      if (o_bb[1] !== 1) begin bad++; $display("FAIL busy9_nobyp cyc%0d got=%b want=1", cyc, o_bb[1]); end
      if (o_bb[0] !== (cyc == 3 ? 1'b0 : 1'b1))
        begin bad++; $display("FAIL busy9_byp cyc%0d got=%b want=%b", cyc, o_bb[0], cyc != 3); end
      tick(); idle();
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      total += 2;
      if (o_bb[c] !== 0) begin bad++; $display("FAIL busy9_after cfg%0d got=%b want=0", c, o_bb[c]); end
      if (o_da[c] !== 32'h0000_0909) begin bad++; $display("FAIL r9_data cfg%0d got=%h want=00000909", c, o_da[c]); end
    end
    $display("txn scoreboard r9 reserve/retire");
  endtask

  task automatic test_same_cycle();
    word_t d = $urandom;
    rsv_en = 1; rsv_addr = 12; wr_en = 1; wr_addr = 12; wr_data = d;
    rd_addr_a = 12; rd_addr_b = 12;
    tick(); idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      total += 3;
      if (o_bb[c] !== 1) begin bad++; $display("FAIL setwins_busy cfg%0d got=%b want=1", c, o_bb[c]); end
      if (o_da[c] !== d) begin bad++; $display("FAIL setwins_da cfg%0d got=%h want=%h", c, o_da[c], d); end
      if (o_db[c] !== d) begin bad++; $display("FAIL setwins_db cfg%0d got=%h want=%h", c, o_db[c], d); end
    end
    wr_en = 1; wr_addr = 12; wr_data = d;
    tick(); idle();
    $display("txn same_cycle rsv+wr r12 data=%h", d);
  endtask

  task automatic test_busy_any();
    reg_idx_t seq [3];
    seq[0] = 3; seq[1] = 4; seq[2] = 0;
    rd_addr_a = 0; rd_addr_b = 3;
    for (int k = 0; k < 3; k++) begin
      rsv_en = 1; rsv_addr = seq[k];
      tick(); idle();
      #1;
      total += 2;
      if (o_ba[0] !== 0) begin bad++; $display("FAIL r0_never_busy k%0d got=%b want=0", k, o_ba[0]); end
      if (o_any[0] !== 1) begin bad++; $display("FAIL any_rsv k%0d got=%b want=1", k, o_any[0]); end
    end
    total += 2;
    if (o_ba[1] !== 1) begin bad++; $display("FAIL r0_plain_busy got=%b want=1", o_ba[1]); end
    if (o_bb[0] !== 1) begin bad++; $display("FAIL r3_busy got=%b want=1", o_bb[0]); end
    wr_en = 1; wr_addr = 3; wr_data = $urandom;
    tick();
    wr_addr = 4; wr_data = $urandom;
    #1;
    total++;
    if (o_any[0] !== 1) begin bad++; $display("FAIL any_before_last got=%b want=0x1", o_any[0]); end
    tick(); idle();
    #1;
    total += 2;
    if (o_any[0] !== 0) begin bad++; $display("FAIL any_drained got=%b want=0", o_any[0]); end
    if (o_any[1] !== 1) begin bad++; $display("FAIL any_r0_plain got=%b want=1", o_any[1]); end
    wr_en = 1; wr_addr = 0; wr_data = 0;
    tick(); idle();
    $display("txn busy_any drain r3/r4/r0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en     = ($urandom_range(0, 2) != 0);
      rsv_en    = ($urandom_range(0, 2) == 0);
      wr_addr   = reg_idx_t'($urandom_range(0, (n % 4 == 0) ? 31 : 7));
      rsv_addr  = reg_idx_t'($urandom_range(0, (n % 4 == 1) ? 31 : 7));
      rd_addr_a = reg_idx_t'($urandom_range(0, (n % 4 == 2) ? 31 : 7));
      rd_addr_b = (n % 5 == 0) ? rd_addr_a : reg_idx_t'($urandom_range(0, 7));
      wr_data   = $urandom;
      #1;
      for (int c = 0; c < 2; c++) begin
        total += 5;
        if (o_da[c] !== exp_rd(c, rd_addr_a))
          begin bad++; $display("FAIL rnd_da n%0d cfg%0d got=%h want=%h", n, c, o_da[c], exp_rd(c, rd_addr_a)); end
        if (o_db[c] !== exp_rd(c, rd_addr_b))
          begin bad++; $display("FAIL rnd_db n%0d cfg%0d got=%h want=%h", n, c, o_db[c], exp_rd(c, rd_addr_b)); end
        if (o_ba[c] !== exp_busy(c, rd_addr_a))
          begin bad++; $display("FAIL rnd_ba n%0d cfg%0d got=%b want=%b", n, c, o_ba[c], exp_busy(c, rd_addr_a)); end
        if (o_bb[c] !== exp_busy(c, rd_addr_b))
          begin bad++; $display("FAIL rnd_bb n%0d cfg%0d got=%b want=%b", n, c, o_bb[c], exp_busy(c, rd_addr_b)); end
        if (o_any[c] !== exp_any(c))
          begin bad++; $display("FAIL rnd_any n%0d cfg%0d got=%b want=%b", n, c, o_any[c], exp_any(c)); end
      end
      if (n % 50 == 0)
        $display("txn rnd n=%0d wr=%b@%0d rsv=%b@%0d rd=%0d/%0d", n, wr_en, wr_addr, rsv_en, rsv_addr, rd_addr_a, rd_addr_b);
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); rd_addr_a = 0; rd_addr_b = 0; rst = 1;
    #1;
    test_reset();
    test_async_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_same_cycle();
    test_busy_any();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
